dp_memory: RTL and testbench

Parametrised dual-port word memory for the stack CPU: read-only fetch port A plus read/write data port B, both with registered one-cycle reads. Replaces the fixed 32×8 memory. Adds a hardware clear sequencer that zeroes every word after reset or on request, and a `ready` flag that gates all accesses until clearing is done.

---
 rtl/memory_pkg.sv | 13 +
 rtl/dp_memory.sv | 111 +++++++++++
 tb/tb_dp_memory.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared types and default sizing for the stack CPU word memory.
// Keeps the clear-sequencer state encoding and default geometry in one place.
package memory_pkg;

   typedef enum logic [0:0] {
      MEM_CLEAR,
      MEM_IDLE
   } mem_state_t;

   localparam int MEM_DATA_W = 8;
   localparam int MEM_ADDR_W = 5;

endpackage

// File: rtl/dp_memory.sv
// Dual-port word memory: read-only fetch port A, read/write data port B,
// both with registered one-cycle reads, plus a hardware clear sequencer.
module dp_memory
   import memory_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              ready,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_valid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_valid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              rej
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   mem_state_t        state;
   mem_state_t        state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_next;

   logic a_fire;
   logic b_read_fire;
   logic b_write_fire;
   logic any_req;

   assign a_fire       = a_req & ready;
   assign b_read_fire  = b_req & ~b_we & ready;
   assign b_write_fire = b_req & b_we & ready;
   assign any_req      = a_req | b_req;

   // Clear walks ptr through every word; the wrap back to 0 leaves it ready for the next clear.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      case (state)
         MEM_CLEAR: begin
            ptr_next = ptr + 1'b1;
            if (ptr == '1) begin
               state_next = MEM_IDLE;
            end
         end
         MEM_IDLE: begin
            if (clear_req) begin
               state_next = MEM_CLEAR;
               ptr_next   = '0;
            end
         end
         default: begin
            state_next = MEM_CLEAR;
            ptr_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MEM_CLEAR;
         ptr   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         ready <= (state_next == MEM_IDLE);
      end
   end

   // Single write point for the array: clear sequencer has priority, port B only when idle.
   always_ff @(posedge clk) begin
      if (state == MEM_CLEAR) begin
         mem[ptr] <= '0;
      end else if (b_write_fire) begin
         mem[b_addr] <= b_wdata;
      end
   end

   // Non-blocking reads give read-before-write on a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid <= 1'b0;
         a_rdata <= '0;
         b_valid <= 1'b0;
         b_rdata <= '0;
         rej     <= 1'b0;
      end else begin
         a_valid <= a_fire;
         b_valid <= b_read_fire;
         rej     <= any_req & ~ready;
         if (a_fire) begin
            a_rdata <= mem[a_addr];
         end
         if (b_read_fire) begin
            b_rdata <= mem[b_addr];
         end
      end
   end

endmodule

// File: tb/tb_dp_memory.sv
// Directed self-checking bench for dp_memory with default geometry (32 x 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dp_memory;

   logic       clk;
   logic       rst;
   logic       clear_req;
   logic       ready;
   logic       a_req;
   logic [4:0] a_addr;
   logic       a_valid;
   logic [7:0] a_rdata;
   logic       b_req;
   logic       b_we;
   logic [4:0] b_addr;
   logic [7:0] b_wdata;
   logic       b_valid;
   logic [7:0] b_rdata;
   logic       rej;

   int compared;
   int mismatched;

   dp_memory dut (
      .clk      (clk),
      .rst      (rst),
      .clear_req(clear_req),
      .ready    (ready),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_valid  (a_valid),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_valid  (b_valid),
      .b_rdata  (b_rdata),
      .rej      (rej)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear_req = 1'b0;
      a_req     = 1'b0;
      a_addr    = '0;
      b_req     = 1'b0;
      b_we      = 1'b0;
      b_addr    = '0;
      b_wdata   = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      compared++;
      if ({ready, a_valid, b_valid, rej} !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_flags got %b want 0000", {ready, a_valid, b_valid, rej});
      end
      compared++;
      if ({a_rdata, b_rdata} !== 16'h0000) begin
         mismatched++;
         $display("[TB] FAIL reset_rdata got %h want 0000", {a_rdata, b_rdata});
      end
   endtask

   task automatic test_release_clear();
      int cnt;
      rst = 1'b0;
      cnt = 0;
      while (!ready && cnt < 100) begin
         tick();
         cnt++;
         if (cnt == 31) begin
            compared++;
            if (ready !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL ready_edge31 got %b want 0", ready);
            end
         end
      end
      compared++;
      if (cnt !== 32) begin
         mismatched++;
         $display("[TB] FAIL release_clear_len got %0d want 32", cnt);
      end
   endtask

   task automatic test_cleared_reads();
      logic [4:0] addrs [3];
      addrs[0] = 5'd0;
      addrs[1] = 5'd15;
      addrs[2] = 5'd31;
      for (int i = 0; i < 3; i++) begin
         a_req  = 1'b1;
         a_addr = addrs[i];
         tick();
         compared++;
         if (a_valid !== 1'b1 || a_rdata !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL cleared_read addr %0d got v=%b d=%h want v=1 d=00",
                     addrs[i], a_valid, a_rdata);
         end
         a_req = 1'b0;
         tick();
         compared++;
         if (a_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL a_valid_pulse got %b want 0", a_valid);
         end
      end
   endtask

   task automatic test_write_read();
      b_req   = 1'b1;
      b_we    = 1'b1;
      b_addr  = 5'd3;
      b_wdata = 8'h9D;
      tick();
      compared++;
      if (b_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b_valid_on_write got %b want 0", b_valid);
      end
      b_req  = 1'b0;
      b_we   = 1'b0;
      a_req  = 1'b1;
      a_addr = 5'd3;
      tick();
      compared++;
      if (a_valid !== 1'b1 || a_rdata !== 8'h9D) begin
         mismatched++;
         $display("[TB] FAIL write_then_read got v=%b d=%h want v=1 d=9d", a_valid, a_rdata);
      end
      a_req = 1'b0;
      b_req = 1'b1;
      b_addr = 5'd3;
      tick();
      compared++;
      if (b_valid !== 1'b1 || b_rdata !== 8'h9D) begin
         mismatched++;
         $display("[TB] FAIL port_b_read got v=%b d=%h want v=1 d=9d", b_valid, b_rdata);
      end
      b_req = 1'b0;
      tick();
      compared++;
      if (b_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b_valid_pulse got %b want 0", b_valid);
      end
   endtask

   task automatic test_collision();
      b_req   = 1'b1;
      b_we    = 1'b1;
      b_addr  = 5'd7;
      b_wdata = 8'h55;
      tick();
      b_wdata = 8'hAA;
      a_req   = 1'b1;
      a_addr  = 5'd7;
      tick();
      compared++;
      if (a_rdata !== 8'h55) begin
         mismatched++;
         $display("[TB] FAIL collision_old got %h want 55", a_rdata);
      end
      b_req = 1'b0;
      b_we  = 1'b0;
      tick();
      compared++;
      if (a_valid !== 1'b1 || a_rdata !== 8'hAA) begin
         mismatched++;
         $display("[TB] FAIL collision_new got v=%b d=%h want v=1 d=aa", a_valid, a_rdata);
      end
      a_addr = 5'd3;
      tick();
      compared++;
      if (a_valid !== 1'b1 || a_rdata !== 8'h9D) begin
         mismatched++;
         $display("[TB] FAIL back_to_back got v=%b d=%h want v=1 d=9d", a_valid, a_rdata);
      end
      a_req = 1'b0;
      tick();
   endtask

   task automatic test_clear_req();
      int cnt;
      b_req   = 1'b1;
      b_we    = 1'b1;
      b_addr  = 5'd30;
      b_wdata = 8'h10;
      tick();
      idle_inputs();
      clear_req = 1'b1;
      tick();
      compared++;
      if (ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL clear_req_ready got %b want 0", ready);
      end
      cnt = 0;
      while (!ready && cnt < 100) begin
         clear_req = (cnt == 3);
         b_req     = (cnt == 6);
         b_we      = 1'b0;
         b_addr    = 5'd3;
         tick();
         cnt++;
         if (cnt == 7) begin
            compared++;
            if (rej !== 1'b1 || b_valid !== 1'b0 || b_rdata !== 8'h9D) begin
               mismatched++;
               $display("[TB] FAIL reject got rej=%b v=%b d=%h want rej=1 v=0 d=9d",
                        rej, b_valid, b_rdata);
            end
         end
         if (cnt == 8) begin
            compared++;
            if (rej !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL rej_pulse got %b want 0", rej);
            end
         end
      end
      idle_inputs();
      compared++;
      if (cnt !== 32) begin
         mismatched++;
         $display("[TB] FAIL clear_req_len got %0d want 32", cnt);
      end
      a_req  = 1'b1;
      a_addr = 5'd30;
      tick();
      compared++;
      if (a_valid !== 1'b1 || a_rdata !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL cleared_addr30 got v=%b d=%h want v=1 d=00", a_valid, a_rdata);
      end
      a_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      b_req   = 1'b1;
      b_we    = 1'b1;
      b_addr  = 5'd5;
      b_wdata = 8'h77;
      tick();
      b_we   = 1'b0;
      a_req  = 1'b1;
      a_addr = 5'd5;
      tick();
      idle_inputs();
      compared++;
      if (a_rdata !== 8'h77 || b_rdata !== 8'h77) begin
         mismatched++;
         $display("[TB] FAIL pre_reset_data got a=%h b=%h want 77 77", a_rdata, b_rdata);
      end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
      end
      rst = 1'b1;
      #1;
      compared++;
      if ({ready, a_valid, b_valid, rej, a_rdata, b_rdata} !== 20'h0_0000) begin
         mismatched++;
         $display("[TB] FAIL mid_clear_reset got r=%b av=%b bv=%b rej=%b a=%h b=%h want all 0",
                  ready, a_valid, b_valid, rej, a_rdata, b_rdata);
      end
      tick();
      rst = 1'b0;
      cnt = 0;
      while (!ready && cnt < 100) begin
         tick();
         cnt++;
      end
      compared++;
      if (cnt !== 32) begin
         mismatched++;
         $display("[TB] FAIL restart_clear_len got %0d want 32", cnt);
      end
      a_req  = 1'b1;
      a_addr = 5'd5;
      tick();
      compared++;
      if (a_valid !== 1'b1 || a_rdata !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL after_restart_read got v=%b d=%h want v=1 d=00", a_valid, a_rdata);
      end
      a_req = 1'b0;
      tick();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_release_clear();
      test_cleared_reads();
      test_write_read();
      test_collision();
      test_clear_req();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
